// File: rtl/nios_system_trace_pkg.sv
// Shared types and constants for the multicore trace arbiter.
// Optional build macro: TRACE_ARB_TIMESTAMP_EN adds a 16-bit cycle stamp
// in the MSBs of the trace RAM write word.
package nios_system_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } trace_state_e;

    localparam int unsigned DEF_NUM_CPU = 4;
    localparam int unsigned DEF_DATA_W  = 30;
    localparam int unsigned DEF_CNT_W   = 4;
    localparam int unsigned DEF_ADDR_W  = 10;
    localparam int unsigned DEF_ID_W    = 3;

    localparam int unsigned TS_W = 16;
`ifdef TRACE_ARB_TIMESTAMP_EN
    localparam int unsigned WDATA_TS_W = TS_W;
`else
    localparam int unsigned WDATA_TS_W = 0;
`endif

    // Field offsets of {ts, id, count, buffer} for the default widths
    localparam int unsigned OFS_BUF = 0;
    localparam int unsigned OFS_CNT = DEF_DATA_W;
    localparam int unsigned OFS_ID  = DEF_DATA_W + DEF_CNT_W;
    localparam int unsigned OFS_TS  = DEF_DATA_W + DEF_CNT_W + DEF_ID_W;

    // Total write-word width for a given field set
    function automatic int unsigned wdata_w(input int unsigned id_w,
                                            input int unsigned cnt_w,
                                            input int unsigned data_w);
        return WDATA_TS_W + id_w + cnt_w + data_w;
    endfunction

endpackage

// File: rtl/nios_system_rr_arbiter.sv
// Round-robin one-hot grant with a last-grant pointer that advances on grant.
module nios_system_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             grant_en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] last_q;
    int unsigned      idx;
    logic             found;

    // Search starting one past the last winner, wrapping modulo N
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = (32'(last_q) + off) % N;
            if (grant_en && !found && req[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                grant_idx          = IDX_W'(idx);
                found              = 1'b1;
            end
        end
    end

    // Last-grant pointer; reset so core 0 wins first
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            last_q <= IDX_W'(N - 1);
        end else if (found) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/nios_system_trace_arbiter.sv
// Shares one trace RAM write port among the per-core OCI trace outputs.
// Optional build macro: TRACE_ARB_TIMESTAMP_EN (16-bit cycle stamp in wdata MSBs).
module nios_system_trace_arbiter
    import nios_system_trace_pkg::*;
#(
    parameter int unsigned NUM_CPU = DEF_NUM_CPU,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned ID_W    = DEF_ID_W
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    enable,
    input  logic                                    wrap_mode,
    input  logic                                    clear,
    input  logic [NUM_CPU-1:0]                      req_valid,
    input  logic [NUM_CPU*DATA_W-1:0]               req_buffer,
    input  logic [NUM_CPU*CNT_W-1:0]                req_count,
    output logic [NUM_CPU-1:0]                      req_ready,
    output logic                                    mem_we,
    output logic [ADDR_W-1:0]                       mem_addr,
    output logic [wdata_w(ID_W, CNT_W, DATA_W)-1:0] mem_wdata,
    output logic [ADDR_W:0]                         wr_ptr,
    output logic                                    full,
    output logic                                    wrapped,
    output logic                                    busy
);

    localparam int unsigned IDX_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    trace_state_e      state_q, state_d;
    logic              grant_en;
    logic [IDX_W-1:0]  grant_idx;
    logic [DATA_W-1:0] sel_buf;
    logic [CNT_W-1:0]  sel_cnt;
    logic              xfer, do_write, last_addr, stop_hit;

    assign grant_en  = (state_q == ST_RUN) && reset_n && !clear;
    assign xfer      = |req_ready;
    assign do_write  = xfer && (sel_cnt != '0);
    assign last_addr = (wr_ptr[ADDR_W-1:0] == {ADDR_W{1'b1}});
    assign stop_hit  = do_write && last_addr && !wrap_mode;
    assign busy      = (state_q == ST_RUN);

    nios_system_rr_arbiter #(
        .N     (NUM_CPU),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .grant_en  (grant_en),
        .req       (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    // Select the granted core's word and count
    always_comb begin
        sel_buf = '0;
        sel_cnt = '0;
        for (int unsigned i = 0; i < NUM_CPU; i++) begin
            if (32'(grant_idx) == i) begin
                sel_buf = req_buffer[i*DATA_W +: DATA_W];
                sel_cnt = req_count[i*CNT_W +: CNT_W];
            end
        end
    end

    // Next-state logic; clear overrides everything including STOPPED
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop_hit)     state_d = ST_STOPPED;
                else if (!enable) state_d = ST_IDLE;
            end
            ST_STOPPED: state_d = ST_STOPPED;
            default:    state_d = ST_IDLE;
        endcase
        if (clear) state_d = enable ? ST_RUN : ST_IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

`ifdef TRACE_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle stamp, restarted by clear
    always_ff @(posedge clk) begin
        if (!reset_n || clear) ts_q <= '0;
        else                   ts_q <= ts_q + TS_W'(1);
    end
`endif

    // Write port and pointer/flag registers; write lands one cycle after grant
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_ptr    <= '0;
            full      <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            mem_we <= do_write;
            if (clear) begin
                wr_ptr  <= '0;
                full    <= 1'b0;
                wrapped <= 1'b0;
            end else if (do_write) begin
                mem_addr <= wr_ptr[ADDR_W-1:0];
`ifdef TRACE_ARB_TIMESTAMP_EN
                mem_wdata <= {ts_q, ID_W'(grant_idx), sel_cnt, sel_buf};
`else
                mem_wdata <= {ID_W'(grant_idx), sel_cnt, sel_buf};
`endif
                if (last_addr && !wrap_mode) begin
                    full   <= 1'b1;
                    wr_ptr <= (ADDR_W+1)'(DEPTH);
                end else begin
                    if (last_addr) wrapped <= 1'b1;
                    wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nios_system_trace_arbiter.sv
// Directed bench for the trace arbiter, built with an 8-deep trace RAM.
module tb_nios_system_trace_arbiter;

    localparam int unsigned NCPU = 4;
    localparam int unsigned DW   = 30;
    localparam int unsigned CW   = 4;
    localparam int unsigned AW   = 3;
    localparam int unsigned IW   = 3;
    localparam int unsigned WDW  = nios_system_trace_pkg::WDATA_TS_W + IW + CW + DW;

    logic               clk = 1'b0;
    logic               reset_n, enable, wrap_mode, clear;
    logic [NCPU-1:0]    req_valid;
    logic [NCPU*DW-1:0] req_buffer;
    logic [NCPU*CW-1:0] req_count;
    logic [NCPU-1:0]    req_ready;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [WDW-1:0]     mem_wdata;
    logic [AW:0]        wr_ptr;
    logic               full, wrapped, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nios_system_trace_arbiter #(
        .NUM_CPU (NCPU),
        .DATA_W  (DW),
        .CNT_W   (CW),
        .ADDR_W  (AW),
        .ID_W    (IW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .wrap_mode  (wrap_mode),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_buffer (req_buffer),
        .req_count  (req_count),
        .req_ready  (req_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .wr_ptr     (wr_ptr),
        .full       (full),
        .wrapped    (wrapped),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic [DW-1:0] b, input logic [CW-1:0] c);
        req_buffer[i*DW +: DW] = b;
        req_count[i*CW +: CW]  = c;
    endtask

    logic [36:0] exp_w;
    int          g;

    initial begin
        reset_n = 1'b0; enable = 1'b0; wrap_mode = 1'b1; clear = 1'b0;
        req_valid = '0; req_buffer = '0; req_count = '0;
        repeat (2) step();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_ptr", 64'(wr_ptr), 64'd0);
        chk("rst_flags", 64'({full, wrapped, busy}), 64'd0);

        reset_n = 1'b1;
        step();
        chk("idle_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        step();
        chk("run_busy", 64'(busy), 64'd1);

        // Single core 2 word
        set_core(2, 30'h2AAAAAAA, 4'd5);
        req_valid = 4'b0100;
        #1 chk("t1_ready", 64'(req_ready), 64'h4);
        step();
        req_valid = '0;
        chk("t1_we", 64'(mem_we), 64'd1);
        chk("t1_addr", 64'(mem_addr), 64'd0);
        chk("t1_wdata", 64'(mem_wdata[36:0]), 64'({3'd2, 4'd5, 30'h2AAAAAAA}));
        chk("t1_ptr", 64'(wr_ptr), 64'd1);

        // Count-zero word on core 1 is discarded
        set_core(1, 30'h1234, 4'd0);
        req_valid = 4'b0010;
        #1 chk("z_ready", 64'(req_ready), 64'h2);
        step();
        req_valid = '0;
        chk("z_we", 64'(mem_we), 64'd0);
        chk("z_ptr", 64'(wr_ptr), 64'd1);

        // All cores valid: rotation resumes at core 2, address wraps after 7
        for (int i = 0; i < 4; i++) set_core(i, DW'(32'h100 + i), CW'(i + 1));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            g = (2 + k) % 4;
            #1 chk("rr_ready", 64'(req_ready), 64'(1 << g));
            step();
            exp_w = {3'(g), 4'(g + 1), 30'(32'h100 + g)};
            chk("rr_we", 64'(mem_we), 64'd1);
            chk("rr_addr", 64'(mem_addr), 64'((1 + k) % 8));
            chk("rr_wdata", 64'(mem_wdata[36:0]), 64'(exp_w));
            chk("rr_wrapped", 64'(wrapped), 64'(k >= 6));
        end
        req_valid = '0;
        chk("rr_ptr", 64'(wr_ptr), 64'd9);
        chk("rr_full", 64'(full), 64'd0);

        // Clear blocks a coincident transfer and resets pointer/flags
        req_valid = 4'hF;
        clear = 1'b1;
        #1 chk("clr_ready", 64'(req_ready), 64'd0);
        step();
        clear = 1'b0;
        req_valid = '0;
        chk("clr_we", 64'(mem_we), 64'd0);
        chk("clr_ptr", 64'(wr_ptr), 64'd0);
        chk("clr_wrapped", 64'(wrapped), 64'd0);
        chk("clr_busy", 64'(busy), 64'd1);

        // Stop-on-full with core 0 streaming
        wrap_mode = 1'b0;
        set_core(0, 30'h3000_0001, 4'd3);
        req_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            #1 chk("st_ready", 64'(req_ready), 64'h1);
            step();
            chk("st_we", 64'(mem_we), 64'd1);
            chk("st_addr", 64'(mem_addr), 64'(k));
            chk("st_full", 64'(full), 64'(k == 7));
        end
        #1 chk("st_ready_off", 64'(req_ready), 64'd0);
        chk("st_busy", 64'(busy), 64'd0);
        chk("st_ptr", 64'(wr_ptr), 64'd8);
        step();
        chk("st_we_off", 64'(mem_we), 64'd0);
        chk("st_full_hold", 64'(full), 64'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("st_clr_full", 64'(full), 64'd0);
        chk("st_clr_ptr", 64'(wr_ptr), 64'd0);
        chk("st_clr_busy", 64'(busy), 64'd1);
        #1 chk("st_res_ready", 64'(req_ready), 64'h1);
        step();
        chk("st_res_we", 64'(mem_we), 64'd1);
        chk("st_res_addr", 64'(mem_addr), 64'd0);
        chk("st_res_ptr", 64'(wr_ptr), 64'd1);

        // Reset mid-stream
        step();
        reset_n = 1'b0;
        #1 chk("mr_ready_low", 64'(req_ready), 64'd0);
        step();
        chk("mr_we", 64'(mem_we), 64'd0);
        chk("mr_addr", 64'(mem_addr), 64'd0);
        chk("mr_wdata", 64'(mem_wdata), 64'd0);
        chk("mr_ptr", 64'(wr_ptr), 64'd0);
        chk("mr_flags", 64'({full, wrapped, busy}), 64'd0);
        chk("mr_ready", 64'(req_ready), 64'd0);
        reset_n = 1'b1;
        req_valid = '0;
        step();
        chk("mr_rerun", 64'(busy), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios_system_trace_arbiter.md
# nios_system_trace_arbiter

Round-robin arbiter that shares a single on-chip trace RAM write port among the OCI debug-trace outputs of all Nios II cores in the multicore system. Each core presents a 30-bit trace word plus a 4-bit count; the arbiter grants one core per cycle, tags the word with the core ID and writes it at the next trace address. It supports wrap and stop-on-full modes and sits between the per-core OCI blocks and the shared trace memory.

## Interface
- NUM_CPU, 4, number of requesting cores (2..8)
- DATA_W, 30, trace word width
- CNT_W, 4, trace count width
- ADDR_W, 10, trace RAM address width (depth = 2**ADDR_W)
- ID_W, 3, core-ID field width
- clk  in  1  single clock, rising edge
- reset_n  in  1  reset; synchronous, active-low
- enable  in  1  capture enable
- wrap_mode  in  1  1: wrap at end of RAM; 0: stop when full
- clear  in  1  one-cycle pulse: pointer and flags to zero
- req_valid  in  NUM_CPU  per-core word available
- req_buffer  in  NUM_CPU*DATA_W  packed trace words, core 0 in LSBs
- req_count  in  NUM_CPU*CNT_W  packed trace counts
- req_ready  out  NUM_CPU  one-hot grant; transfer = valid & ready
- mem_we  out  1  trace RAM write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  ID_W+CNT_W+DATA_W (+16 with timestamp)  {id, count, buffer}
- wr_ptr  out  ADDR_W+1  words written since clear (saturates at depth when stopped)
- full  out  1  stopped on full (wrap_mode=0)
- wrapped  out  1  sticky, pointer has wrapped at least once
- busy  out  1  state == RUN

## Operation
- States: IDLE, RUN, STOPPED. Reset → IDLE.
- IDLE: req_ready=0. enable=1 → RUN.
- RUN: enable=0 → IDLE (pointer kept). Grant lowest index at or after (last_grant+1) mod NUM_CPU among req_valid; req_ready is combinational from state, valid and last_grant. last_grant updates only on a transfer; reset value NUM_CPU-1 so core 0 wins first.
- A transfer with count==0 is accepted and discarded: no write, no pointer advance, last_grant still updates.
- Write of address depth-1 with wrap_mode=0 → STOPPED, full=1. With wrap_mode=1 address wraps to 0, wrapped=1.
- STOPPED: req_ready=0; leaves only on clear or reset.
- clear: pointer, full, wrapped, last_grant to reset values; next state RUN if enable else IDLE. A transfer coinciding with clear is ignored (ready forced 0 that cycle).
- wrap_mode change takes effect on the next write.

## Timing
- Grant to write latency 1 cycle: transfer in cycle N → mem_we, mem_addr, mem_wdata registered in cycle N+1.
- Max throughput one word per cycle; a core continuously valid with others idle is granted every cycle.
- Fairness: with all NUM_CPU valid, each core granted exactly once every NUM_CPU cycles.
- Reset values: req_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_ptr=0, full=0, wrapped=0, busy=0.
- full asserts same cycle as the final mem_we.

## Configuration
- TRACE_ARB_TIMESTAMP_EN defined: 16-bit free-running cycle counter (reset 0, wraps, cleared by clear) prepended as MSBs of mem_wdata; sampled at the transfer cycle.
- Undefined: no counter, mem_wdata is ID_W+CNT_W+DATA_W bits.

## Structure
- Shared package nios_system_trace_pkg: state enum, default widths, timestamp width constant, wdata field offsets.
- One sub-module: nios_system_rr_arbiter (parameterised round-robin grant from request vector and last grant, purely combinational plus last-grant register).

## Test plan
- Reset, enable=1, core 2 valid with buffer 0x2AAAAAAA, count 5 → one-cycle ready[2], next cycle mem_we=1, addr 0, wdata {2,5,0x2AAAAAAA}, wr_ptr=1.
- All 4 cores valid continuously → grant order 0,1,2,3,0… and addresses 0,1,2,3,4 consecutive.
- ADDR_W=3, wrap_mode=0, single core streaming → 8 writes, full=1 with write 7, ready low thereafter; clear → wr_ptr=0, full=0, writes resume at 0.
- ADDR_W=3, wrap_mode=1 → 9th write goes to addr 0, wrapped=1, no stall.
- Core 1 valid with count 0 → ready[1] pulses, no mem_we, wr_ptr unchanged; next grant starts from core 2.
- reset_n low mid-stream → next cycle all outputs at reset values, state IDLE.
